wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning register data width.
REQ-002 SHALL have parameter DEPTH, default 2, meaning entries per requester queue (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 exe_valid, exe_ready  input/output  1 each  ALU write-back request handshake.
REQ-006 exe_addr, exe_data  input  4/N  ALU destination register and value.
REQ-007 mem_valid, mem_ready  input/output  1 each  load write-back request handshake.
REQ-008 mem_addr, mem_data  input  4/N  load destination register and value.
REQ-009 WE3, A3, WD3  output  1/4/N  register-file write port, driven from registers.
REQ-010 pending_mask  output  16  bit r set while any write to register r is queued or on the port.
REQ-011 stall_decode  output  1  decode must hold; set when either queue is full.

Function
REQ-012 A request SHALL be accepted only in a cycle with valid and ready both high; data is captured into that requester's FIFO queue.
REQ-013 exe_ready SHALL equal NOT full(exe queue); mem_ready SHALL equal NOT full(mem queue); neither depends combinationally on valid.
REQ-014 Each cycle at most one queue head SHALL be popped into the output registers; WE3 high the next cycle with that head's A3/WD3 (latency enqueue-to-WE3 >= 1 cycle, exactly 1 with no contention and empty queue).
REQ-015 Arbiter SHALL be round-robin between two states LAST_EXE and LAST_MEM: with both heads present, grant the requester not granted last; with one present, grant it; update the state only on a grant.
REQ-016 After reset the state SHALL be LAST_MEM (exe wins the first tie).
REQ-017 With no head present, WE3 SHALL be 0 the next cycle; A3/WD3 hold their previous values.
REQ-018 Simultaneous push and pop on a full queue SHALL NOT be allowed (ready is low); push and pop on a non-full queue SHALL both occur, count unchanged.
REQ-019 Queue pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-020 pending_mask SHALL be the registered OR of one-hot(addr) over all valid queue entries and the output register when WE3=1, updated every cycle.
REQ-021 Writes to register 15 SHALL be arbitrated like any other register.
REQ-022 Two queued writes to the same register from different requesters SHALL be issued in grant order; write-after-write ordering is the decode stage's responsibility via pending_mask.
REQ-023 stall_decode SHALL equal NOT exe_ready OR NOT mem_ready.

Reset
REQ-024 While rst_n=0: queues empty, WE3=0, A3=0, WD3=0, pending_mask=0, arbiter state LAST_MEM, both ready=1, stall_decode=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued writes with no further WE3 pulse; operation resumes on the first clock edge after rst_n rises.

Structure
REQ-026 wb_req_t (addr, data), arb_state_t (LAST_EXE, LAST_MEM) and REG_COUNT=16 SHALL live in stages_definition_pkg.
REQ-027 The queue SHALL be a sub-module wb_fifo instantiated twice, parameterised by N and DEPTH.

Verification
REQ-028 Single exe push (addr 3, data 0xA5) into an idle block -> WE3=1, A3=3, WD3=0xA5 one cycle later; pending_mask=0x0008 during that cycle.
REQ-029 exe (r1,0x11) and mem (r2,0x22) pushed same cycle after reset -> r1 written cycle 1, r2 cycle 2.
REQ-030 Both requesters valid continuously for 6 cycles -> grants alternate exe,mem,...; stall_decode asserts once a queue holds 2 entries; no request lost.
REQ-031 mem pushes 3 entries back-to-back with the port blocked by a constant exe stream -> mem_ready drops after 2 accepted entries; third is accepted only after a mem pop.
REQ-032 rst_n pulled low with 3 entries queued -> WE3=0 immediately, pending_mask=0, both ready=1; no writes appear after release.
REQ-033 exe (r15,0x100) -> WE3 with A3=15, WD3=0x100 next cycle.

Source files
------------

// File: rtl/stages_definition_pkg.sv
// Shared types for the write-back stage: queue payload, arbiter state and register-file sizing.
// The payload data field is sized for the widest supported N; narrower ports zero-extend.
package stages_definition_pkg;

    localparam int unsigned REG_COUNT   = 16;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned WB_DATA_MAX = 64;

    typedef enum logic {
        LAST_EXE,
        LAST_MEM
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [WB_DATA_MAX-1:0] data;
    } wb_req_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [REG_COUNT-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester write-back queue. Besides head/empty/full it reports the register mask of
// the entries that will be resident after this cycle's push/pop, so the top can register it.
module wb_fifo
    import stages_definition_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [ADDR_W-1:0]    push_addr,
    input  logic [N-1:0]         push_data,
    input  logic                 pop,
    output logic [ADDR_W-1:0]    head_addr,
    output logic [N-1:0]         head_data,
    output logic                 empty,
    output logic                 full,
    output logic [REG_COUNT-1:0] addr_mask_next
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] idx;
    logic          do_push;
    logic          do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = mem_q[rd_q].addr;
    assign head_data = mem_q[rd_q].data[N-1:0];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wr_q] = '{addr: push_addr, data: WB_DATA_MAX'(push_data)};
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Mask of the entries resident after the update, walking from the next read pointer.
    always_comb begin
        addr_mask_next = '0;
        idx            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_d + PW'(i);
            if (CW'(i) < count_d) begin
                addr_mask_next = addr_mask_next | reg_onehot(mem_d[idx].addr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter merging ALU and load write-backs onto the single register-file write port.
// The port, arbiter state and pending-register mask are all registered.
module wb_port_arbiter
    import stages_definition_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exe_valid,
    output logic                 exe_ready,
    input  logic [ADDR_W-1:0]    exe_addr,
    input  logic [N-1:0]         exe_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [N-1:0]         mem_data,
    output logic                 WE3,
    output logic [ADDR_W-1:0]    A3,
    output logic [N-1:0]         WD3,
    output logic [REG_COUNT-1:0] pending_mask,
    output logic                 stall_decode
);

    arb_state_t            state_q;
    logic                  exe_full, exe_empty;
    logic                  mem_full, mem_empty;
    logic [ADDR_W-1:0]     exe_head_addr, mem_head_addr;
    logic [N-1:0]          exe_head_data, mem_head_data;
    logic [REG_COUNT-1:0]  exe_mask_next, mem_mask_next;
    logic [REG_COUNT-1:0]  queued_mask_next;
    logic                  exe_push, mem_push;
    logic                  exe_grant, mem_grant;

    assign exe_ready    = ~exe_full;
    assign mem_ready    = ~mem_full;
    assign stall_decode = ~exe_ready | ~mem_ready;
    assign exe_push     = exe_valid & exe_ready;
    assign mem_push     = mem_valid & mem_ready;

    // On a tie the requester not served last wins; a lone head is always served.
    assign exe_grant = ~exe_empty & (mem_empty | (state_q == LAST_MEM));
    assign mem_grant = ~mem_empty & (exe_empty | (state_q == LAST_EXE));

    assign queued_mask_next = exe_mask_next | mem_mask_next;

    wb_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_exe_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (exe_push),
        .push_addr      (exe_addr),
        .push_data      (exe_data),
        .pop            (exe_grant),
        .head_addr      (exe_head_addr),
        .head_data      (exe_head_data),
        .empty          (exe_empty),
        .full           (exe_full),
        .addr_mask_next (exe_mask_next)
    );

    wb_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mem_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (mem_push),
        .push_addr      (mem_addr),
        .push_data      (mem_data),
        .pop            (mem_grant),
        .head_addr      (mem_head_addr),
        .head_data      (mem_head_data),
        .empty          (mem_empty),
        .full           (mem_full),
        .addr_mask_next (mem_mask_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LAST_MEM;
            WE3          <= 1'b0;
            A3           <= '0;
            WD3          <= '0;
            pending_mask <= '0;
        end else begin
            WE3          <= exe_grant | mem_grant;
            pending_mask <= queued_mask_next;
            if (exe_grant) begin
                state_q      <= LAST_EXE;
                A3           <= exe_head_addr;
                WD3          <= exe_head_data;
                pending_mask <= queued_mask_next | reg_onehot(exe_head_addr);
            end else if (mem_grant) begin
                state_q      <= LAST_MEM;
                A3           <= mem_head_addr;
                WD3          <= mem_head_data;
                pending_mask <= queued_mask_next | reg_onehot(mem_head_addr);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus queues expected writes in grant order and a
// negedge monitor compares every WE3 pulse against the head of that queue.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        exe_valid, exe_ready;
    logic [3:0]  exe_addr;
    logic [31:0] exe_data;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [15:0] pending_mask;
    logic        stall_decode;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;

    wb_port_arbiter #(
        .N     (32),
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exe_valid    (exe_valid),
        .exe_ready    (exe_ready),
        .exe_addr     (exe_addr),
        .exe_data     (exe_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .WE3          (WE3),
        .A3           (A3),
        .WD3          (WD3),
        .pending_mask (pending_mask),
        .stall_decode (stall_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [3:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Monitor: every write on the port must match the next expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && WE3 === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%h expected no write", A3, WD3);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_addr", 32'(A3), 32'(mon_e.addr));
                chk("wb_data", WD3, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exe(input logic v, input logic [3:0] a, input logic [31:0] d);
        exe_valid = v;
        exe_addr  = a;
        exe_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [3:0] a, input logic [31:0] d);
        mem_valid = v;
        mem_addr  = a;
        mem_data  = d;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        set_exe(1'b0, 4'd0, 32'd0);
        set_mem(1'b0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    // Both requesters present their next item each cycle; records accepts, mem_ready and stall.
    task automatic run_stream(input int cycles, input int n_exe, input int n_mem,
                              output logic [7:0] eacc, output logic [7:0] macc,
                              output logic [7:0] mrdy, output logic [7:0] stl);
        int ei;
        int mi;
        ei = 0;
        mi = 0;
        eacc = '0;
        macc = '0;
        mrdy = '0;
        stl  = '0;
        for (int c = 0; c < cycles; c++) begin
            set_exe(ei < n_exe, 4'(4 + ei), 32'(32'hE0 + ei));
            set_mem(mi < n_mem, 4'(12 + mi), 32'(32'hD0 + mi));
            mrdy[c] = mem_ready;
            stl[c]  = stall_decode;
            if (exe_valid && exe_ready) begin
                eacc[c] = 1'b1;
                ei++;
            end
            if (mem_valid && mem_ready) begin
                macc[c] = 1'b1;
                mi++;
            end
            tick();
        end
        set_exe(1'b0, 4'd0, 32'd0);
        set_mem(1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eacc, macc, mrdy, stl;
        int snap;

        // Reset state
        rst_n = 1'b0;
        set_exe(1'b0, 4'd0, 32'd0);
        set_mem(1'b0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we3", 32'(WE3), 0);
        chk("rst_a3", 32'(A3), 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_pending", 32'(pending_mask), 0);
        chk("rst_exe_ready", 32'(exe_ready), 1);
        chk("rst_mem_ready", 32'(mem_ready), 1);
        chk("rst_stall", 32'(stall_decode), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single exe push, one-cycle latency
        set_exe(1'b1, 4'd3, 32'hA5);
        sb_push(4'd3, 32'hA5);
        tick();
        set_exe(1'b0, 4'd0, 32'd0);
        chk("single_queued_we3", 32'(WE3), 0);
        chk("single_queued_mask", 32'(pending_mask), 32'h0008);
        tick();
        chk("single_we3", 32'(WE3), 1);
        chk("single_a3", 32'(A3), 3);
        chk("single_wd3", WD3, 32'hA5);
        chk("single_port_mask", 32'(pending_mask), 32'h0008);
        tick();
        chk("idle_we3", 32'(WE3), 0);
        chk("idle_mask", 32'(pending_mask), 0);
        chk("idle_a3_hold", 32'(A3), 3);
        chk("idle_wd3_hold", WD3, 32'hA5);

        // Register 15
        set_exe(1'b1, 4'd15, 32'h100);
        sb_push(4'd15, 32'h100);
        tick();
        set_exe(1'b0, 4'd0, 32'd0);
        tick();
        chk("r15_we3", 32'(WE3), 1);
        chk("r15_a3", 32'(A3), 15);
        chk("r15_wd3", WD3, 32'h100);
        tick();

        // Simultaneous push after reset: exe wins first tie
        reset_dut();
        set_exe(1'b1, 4'd1, 32'h11);
        set_mem(1'b1, 4'd2, 32'h22);
        sb_push(4'd1, 32'h11);
        sb_push(4'd2, 32'h22);
        tick();
        set_exe(1'b0, 4'd0, 32'd0);
        set_mem(1'b0, 4'd0, 32'd0);
        tick();
        chk("tie_first_we3", 32'(WE3), 1);
        chk("tie_first_a3", 32'(A3), 1);
        tick();
        chk("tie_second_we3", 32'(WE3), 1);
        chk("tie_second_a3", 32'(A3), 2);
        tick();
        chk("tie_done_we3", 32'(WE3), 0);

        // Both valid for 6 cycles: strict alternation, no loss
        reset_dut();
        sb_push(4'd4, 32'hE0);  sb_push(4'd12, 32'hD0);
        sb_push(4'd5, 32'hE1);  sb_push(4'd13, 32'hD1);
        sb_push(4'd6, 32'hE2);  sb_push(4'd14, 32'hD2);
        sb_push(4'd7, 32'hE3);  sb_push(4'd15, 32'hD3);
        run_stream(6, 8, 8, eacc, macc, mrdy, stl);
        chk("stream_exe_accepts", 32'(eacc), 32'h17);
        chk("stream_mem_accepts", 32'(macc), 32'h2B);
        chk("stream_mem_ready", 32'(mrdy), 32'h2B);
        chk("stream_stall", 32'(stl), 32'h3C);
        drain("stream_drain");

        // Three mem pushes against a constant exe stream
        reset_dut();
        sb_push(4'd4, 32'hE0);  sb_push(4'd12, 32'hD0);
        sb_push(4'd5, 32'hE1);  sb_push(4'd13, 32'hD1);
        sb_push(4'd6, 32'hE2);  sb_push(4'd14, 32'hD2);
        sb_push(4'd7, 32'hE3);
        run_stream(6, 8, 3, eacc, macc, mrdy, stl);
        chk("blk_exe_accepts", 32'(eacc), 32'h17);
        chk("blk_mem_accepts", 32'(macc), 32'h0B);
        chk("blk_mem_ready", 32'(mrdy), 32'h2B);
        drain("blk_drain");

        // Mid-operation reset with three entries queued
        reset_dut();
        set_exe(1'b1, 4'd1, 32'h1);
        set_mem(1'b1, 4'd2, 32'h2);
        sb_push(4'd1, 32'h1);
        tick();
        set_exe(1'b1, 4'd3, 32'h3);
        set_mem(1'b1, 4'd4, 32'h4);
        tick();
        set_exe(1'b0, 4'd0, 32'd0);
        set_mem(1'b0, 4'd0, 32'd0);
        chk("prerst_mask", 32'(pending_mask), 32'h001E);
        chk("prerst_stall", 32'(stall_decode), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we3", 32'(WE3), 0);
        chk("midrst_mask", 32'(pending_mask), 0);
        chk("midrst_exe_ready", 32'(exe_ready), 1);
        chk("midrst_mem_ready", 32'(mem_ready), 1);
        chk("midrst_stall", 32'(stall_decode), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        snap = writes_seen;
        repeat (6) tick();
        chk("postrst_writes", writes_seen - snap, 0);
        chk("postrst_mask", 32'(pending_mask), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
